// File: rtl/output_pkg.sv
// Shared defaults and state encoding for the output slew limiter.
package output_pkg;

  localparam int W_DEF     = 16;
  localparam int DIV_W_DEF = 8;

  typedef enum logic {
    TRACK = 1'b0,
    SLEW  = 1'b1
  } slew_state_e;

endpackage

// File: rtl/slew_tick_gen.sv
// Update-rate divider: one tick every div+1 cycles. The counter runs
// regardless of hold so the update cadence never drifts.
module slew_tick_gen
  import output_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // >= rather than == so that lowering div below cnt ticks at once instead of wrapping
  assign tick = (cnt_q >= div);

  // Next count: restart on tick, otherwise advance
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + ONE;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/output_slew_limiter.sv
// Slew-rate limiter between the output mux and the DAC interface.
//
//   state | meaning
//   ------+-----------------------------------------------
//   TRACK | last update loaded in directly (out == in)
//   SLEW  | last update was clipped to +/- step toward in
//
module output_slew_limiter
  import output_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] in,
  input  logic        [W-2:0] step,
  input  logic    [DIV_W-1:0] div,
  input  logic                hold,
  output logic signed [W-1:0] out,
  output logic                out_valid,
  output logic                slewing
);

  logic                tick;
  logic signed [W:0]   diff;
  logic        [W:0]   mag;
  logic        [W:0]   step_x;
  logic                limit;
  logic        [W-1:0] stepped;

  slew_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (div),
    .tick  (tick)
  );

  slew_state_e         state_q, state_d;
  logic signed [W-1:0] out_q, out_d;
  logic                valid_q, valid_d;
  logic                slewing_q, slewing_d;

  // Difference carried at W+1 bits so full-scale swings never alias
  assign diff   = {in[W-1], in} - {out_q[W-1], out_q};
  assign mag    = diff[W] ? $unsigned(-diff) : $unsigned(diff);
  assign step_x = {2'b00, step};
  assign limit  = (step != '0) && (mag > step_x);

  // Only used when |diff| > step, so the result lies strictly between out
  // and in and W-bit arithmetic cannot wrap.
  assign stepped = diff[W] ? (out_q - {1'b0, step}) : (out_q + {1'b0, step});

  // Next-state: update only on an unheld tick, otherwise freeze everything
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    slewing_d = slewing_q;
    if (tick && !hold) begin
      valid_d = 1'b1;
      if (limit) begin
        out_d     = stepped;
        state_d   = SLEW;
        slewing_d = 1'b1;
      end else begin
        out_d     = in;
        state_d   = TRACK;
        slewing_d = 1'b0;
      end
    end
  end

  // State, sample and strobe registers; reset aborts any slew in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TRACK;
      out_q     <= '0;
      valid_q   <= 1'b0;
      slewing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      slewing_q <= slewing_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign slewing   = slewing_q;

endmodule

// File: tb/tb_output_slew_limiter.sv
// Bench for output_slew_limiter: a table of single-cycle vectors at div = 0,
// then hand-written multi-cycle sequences. Every out_valid pulse is matched
// against an expected-update queue (value, slewing, cycle).
module tb_output_slew_limiter;

  localparam int W     = 16;
  localparam int SW    = W - 1;
  localparam int DIV_W = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic signed [W-1:0] in_s;
  logic       [SW-1:0] step_s;
  logic    [DIV_W-1:0] div_s;
  logic                hold_s;
  logic signed [W-1:0] out_s;
  logic                out_valid_s;
  logic                slewing_s;

  initial forever #5 clk = ~clk;

  output_slew_limiter #(.W(W), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_s),
    .step      (step_s),
    .div       (div_s),
    .hold      (hold_s),
    .out       (out_s),
    .out_valid (out_valid_s),
    .slewing   (slewing_s)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int val;
    bit slew;
    int cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int in_v;
    int step_v;
    bit hold_v;
    int exp_out;
    bit exp_slew;
  } vec_t;
  vec_t vecs[12];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int i_v, input int s_v, input int d_v, input bit h_v);
    in_s   = W'(i_v);
    step_s = SW'(s_v);
    div_s  = DIV_W'(d_v);
    hold_s = h_v;
  endtask

  task automatic expect_upd(input int v, input bit s, input int c);
    exp_t e;
    e.val  = v;
    e.slew = s;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drained(input string name);
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  // div = 0 for one held cycle leaves the tick counter at 0
  task automatic realign();
    drive(int'(in_s), int'(step_s), 0, 1'b1);
    cycles(1);
  endtask

  // Scoreboard monitor: every out_valid pulse must match the next expected update
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n === 1'b1 && out_valid_s === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got out_valid=1 out=%0d, expected no update (cycle %0d)",
                 out_s, cyc);
      end else begin
        e = sb.pop_front();
        chk("upd_out", int'(out_s), e.val);
        chk("upd_slewing", int'(slewing_s), int'(e.slew));
        if (e.cyc >= 0) chk("upd_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int c;

    vecs[0]  = '{50,     100,   1'b0, 50,     1'b0};
    vecs[1]  = '{77,     100,   1'b1, 50,     1'b0};
    vecs[2]  = '{-300,   100,   1'b0, -50,    1'b1};
    vecs[3]  = '{-300,   100,   1'b0, -150,   1'b1};
    vecs[4]  = '{500,    100,   1'b1, -150,   1'b1};
    vecs[5]  = '{-300,   200,   1'b0, -300,   1'b0};
    vecs[6]  = '{1000,   0,     1'b0, 1000,   1'b0};
    vecs[7]  = '{900,    100,   1'b0, 900,    1'b0};
    vecs[8]  = '{1001,   100,   1'b0, 1000,   1'b1};
    vecs[9]  = '{1001,   100,   1'b0, 1001,   1'b0};
    vecs[10] = '{-32768, 32767, 1'b0, -31766, 1'b1};
    vecs[11] = '{-32768, 0,     1'b0, -32768, 1'b0};

    // Reset state
    rst_n = 1'b0;
    drive(0, 0, 0, 1'b1);
    #12;
    chk("rst_out", int'(out_s), 0);
    chk("rst_valid", int'(out_valid_s), 0);
    chk("rst_slewing", int'(slewing_s), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);

    // Table vectors, one tick per cycle
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].in_v, vecs[i].step_v, 0, vecs[i].hold_v);
      if (!vecs[i].hold_v) expect_upd(vecs[i].exp_out, vecs[i].exp_slew, cyc + 1);
      cycles(1);
      chk($sformatf("vec%0d_out", i), int'(out_s), vecs[i].exp_out);
      chk($sformatf("vec%0d_slewing", i), int'(slewing_s), int'(vecs[i].exp_slew));
      chk($sformatf("vec%0d_valid", i), int'(out_valid_s), int'(!vecs[i].hold_v));
    end
    drive(-32768, 0, 0, 1'b1);
    cycles(2);
    drained("tbl_drain");

    // Full-scale swing from -32768 to 32767 with step 16383
    drive(32767, 16383, 0, 1'b0);
    c = cyc;
    expect_upd(-16385, 1'b1, c + 1);
    expect_upd(-2,     1'b1, c + 2);
    expect_upd(16381,  1'b1, c + 3);
    expect_upd(32764,  1'b1, c + 4);
    expect_upd(32767,  1'b0, c + 5);
    cycles(5);
    chk("ext_final_out", int'(out_s), 32767);
    drive(32767, 16383, 0, 1'b1);
    cycles(2);
    drained("ext_drain");

    // Slew 0 -> 3500 at div = 3, step = 1000
    drive(0, 0, 0, 1'b0);
    expect_upd(0, 1'b0, cyc + 1);
    cycles(1);
    drive(3500, 1000, 3, 1'b0);
    c = cyc;
    expect_upd(1000, 1'b1, c + 4);
    expect_upd(2000, 1'b1, c + 8);
    expect_upd(3000, 1'b1, c + 12);
    expect_upd(3500, 1'b0, c + 16);
    cycles(2);
    chk("slew_between_ticks", int'(out_s), 0);
    cycles(14);
    drive(3500, 1000, 3, 1'b1);
    cycles(6);
    drained("slew_drain");

    // Hold freezes a slew; inputs between ticks are ignored; then step = 0
    realign();
    drive(-5000, 1000, 3, 1'b0);
    c = cyc;
    expect_upd(2500, 1'b1, c + 4);
    cycles(1);
    drive(30000, 5, 3, 1'b0);
    cycles(1);
    drive(-5000, 1000, 3, 1'b0);
    cycles(2);
    drive(7, 1000, 3, 1'b1);
    cycles(9);
    chk("hold_out", int'(out_s), 2500);
    chk("hold_slewing", int'(slewing_s), 1);
    chk("hold_valid", int'(out_valid_s), 0);
    drive(-7, 0, 3, 1'b0);
    expect_upd(-7, 1'b0, c + 16);
    cycles(3);
    drive(-7, 0, 3, 1'b1);
    cycles(2);
    drained("hold_drain");

    // Divider lowered from 200 to 5 while cnt = 50
    realign();
    drive(-7, 0, 200, 1'b0);
    c = cyc;
    cycles(50);
    drive(-7, 0, 5, 1'b0);
    expect_upd(-7, 1'b0, c + 51);
    expect_upd(-7, 1'b0, c + 57);
    expect_upd(-7, 1'b0, c + 63);
    cycles(13);
    drive(-7, 0, 5, 1'b1);
    cycles(7);
    drained("div_drain");

    // Asynchronous reset in the middle of a slew at out = 1200
    drive(0, 0, 0, 1'b0);
    expect_upd(0, 1'b0, cyc + 1);
    cycles(1);
    drive(5000, 400, 0, 1'b0);
    c = cyc;
    expect_upd(400,  1'b1, c + 1);
    expect_upd(800,  1'b1, c + 2);
    expect_upd(1200, 1'b1, c + 3);
    cycles(3);
    chk("pre_rst_out", int'(out_s), 1200);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", int'(out_s), 0);
    chk("async_rst_valid", int'(out_valid_s), 0);
    chk("async_rst_slewing", int'(slewing_s), 0);
    drive(5000, 400, 2, 1'b0);
    cycles(2);
    drained("rst_drain");

    // First tick after release counts from 0; update starts from out = 0
    rst_n = 1'b1;
    c = cyc;
    expect_upd(400, 1'b1, c + 3);
    cycles(3);
    drive(5000, 400, 2, 1'b1);
    cycles(4);
    drained("post_rst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
